// File: rtl/clint_tick_scheduler.sv
// Bus master that arms one hart's CLINT mtimecmp for a periodic, drift-free tick.
// Reads mtime with a hi/lo/hi snapshot, then writes mtimecmp hi-max, lo, hi so mtip never glitches.
module clint_tick_scheduler #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 32,
  parameter int N_CORES       = 1,
  parameter int HART_W        = 1,
  parameter int MTIMECMP_BASE = 16384,
  parameter int MTIME_BASE    = 49144
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_en,
  input  logic [HART_W-1:0]   cfg_hart,
  input  logic [63:0]         cfg_period,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  input  logic [N_CORES-1:0]  mtip,
  output logic                tick,
  output logic [31:0]         tick_count,
  output logic                busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_HI0, S_RD_LO, S_RD_HI1, S_WR_MAX, S_WR_LO, S_WR_HI, S_ARMED, S_DIS
  } state_t;

  localparam logic [ADDR_W-1:0] MT_LO = ADDR_W'(MTIME_BASE);
  localparam logic [ADDR_W-1:0] MT_HI = ADDR_W'(MTIME_BASE + 4);

  state_t              state, next;
  logic [HART_W-1:0]   hart_q;
  logic [63:0]         period_q;
  logic [63:0]         target_q;
  logic [31:0]         hi0_q;
  logic [31:0]         lo_q;
  logic [31:0]         count_q;
  logic                gap_q;
  logic [N_CORES-1:0]  mtip_sh;
  logic [ADDR_W-1:0]   cmp_lo;
  logic [ADDR_W-1:0]   cmp_hi;
  logic [31:0]         rd32;
  logic                is_bus;
  logic                req_wr;
  logic [ADDR_W-1:0]   req_addr;
  logic [31:0]         req_data;
  state_t              adv;
  logic                xfer;

  assign mtip_sh    = mtip >> hart_q;
  assign cmp_lo     = ADDR_W'(MTIMECMP_BASE) + ADDR_W'({hart_q, 3'b000});
  assign cmp_hi     = cmp_lo + ADDR_W'(4);
  assign rd32       = m_rdata[31:0];
  assign tick_count = count_q;
  assign xfer       = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  always_comb begin
    next      = state;
    m_valid   = 1'b0;
    m_address = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    tick      = 1'b0;
    busy      = 1'b1;
    is_bus    = 1'b1;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    adv       = S_IDLE;
    case (state)
      S_IDLE: begin
        busy   = 1'b0;
        is_bus = 1'b0;
        if (cfg_en) next = S_RD_HI0;
      end
      S_ARMED: begin
        busy   = 1'b0;
        is_bus = 1'b0;
        if (!cfg_en) next = S_DIS;
        else if (mtip_sh[0]) begin
          tick = 1'b1;
          next = S_WR_MAX;
        end
      end
      S_RD_HI0: begin req_addr = MT_HI; adv = S_RD_LO; end
      S_RD_LO:  begin req_addr = MT_LO; adv = S_RD_HI1; end
      S_RD_HI1: begin
        req_addr = MT_HI;
        adv      = (rd32 != hi0_q) ? S_RD_LO : S_WR_MAX;
      end
      S_WR_MAX: begin req_wr = 1'b1; req_addr = cmp_hi; req_data = '1;              adv = S_WR_LO; end
      S_WR_LO:  begin req_wr = 1'b1; req_addr = cmp_lo; req_data = target_q[31:0];  adv = S_WR_HI; end
      S_WR_HI:  begin req_wr = 1'b1; req_addr = cmp_hi; req_data = target_q[63:32]; adv = S_ARMED; end
      S_DIS:    begin req_wr = 1'b1; req_addr = cmp_hi; req_data = '1;              adv = S_IDLE; end
      default: begin
        is_bus = 1'b0;
        next   = S_IDLE;
      end
    endcase

    // The registered gap flag forces one idle bus cycle after every completed transfer.
    if (is_bus) begin
      m_valid = !gap_q;
      if (m_valid) begin
        m_address = req_addr;
        m_wdata   = req_wr ? DATA_W'(req_data) : '0;
        m_wstrb   = req_wr ? '1 : '0;
        if (m_ready) next = (!cfg_en && state != S_DIS) ? S_DIS : adv;
      end else if (!cfg_en && state != S_DIS) begin
        next = S_DIS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hart_q   <= '0;
      period_q <= '0;
      target_q <= '0;
      hi0_q    <= '0;
      lo_q     <= '0;
      count_q  <= '0;
      gap_q    <= 1'b0;
    end else begin
      gap_q <= xfer;
      if (state == S_IDLE && cfg_en) begin
        hart_q   <= cfg_hart;
        period_q <= cfg_period;
        count_q  <= '0;
      end
      if (xfer) begin
        case (state)
          S_RD_HI0: hi0_q <= rd32;
          S_RD_LO:  lo_q  <= rd32;
          S_RD_HI1: begin
            if (rd32 != hi0_q) hi0_q <= rd32;
            else               target_q <= {hi0_q, lo_q} + period_q;
          end
          default: ;
        endcase
      end
      // Re-arm from the previous target, not from mtime, so the tick never drifts.
      if (tick) begin
        count_q  <= count_q + 32'd1;
        target_q <= target_q + period_q;
      end
    end
  end

endmodule
